// File: rtl/pingpong_bram.sv
// pingpong_bram: double-buffered simple dual-port memory.
// A producer fills one bank while a consumer drains the other. Ownership of
// each bank passes through a done/ready handshake.
// Optional feature: define PINGPONG_SWAP_CNT_EN to add the swap_count port,
// a 16-bit count of accepted wr_done handoffs.
module pingpong_bram #(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 256,
  parameter  int READ_LATENCY = 1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_done,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_done,
  output logic             rd_avail,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
`ifdef PINGPONG_SWAP_CNT_EN
  ,
  output logic [15:0]      swap_count
`endif
);

  logic             wr_sel;
  logic             rd_sel;
  logic [1:0]       full;
  logic [1:0]       full_next;
  logic             wr_take;
  logic             wr_hand;
  logic             rd_take;
  logic             rd_rel;
  logic             s1_valid;
  logic [WIDTH-1:0] raw_word;

  logic [WIDTH-1:0] bank0 [DEPTH];
  logic [WIDTH-1:0] bank1 [DEPTH];

  // A bank is writable only while it is empty, readable only while full.
  // Because of this the producer and consumer can never share a bank, so
  // the two ports need no collision handling.
  assign wr_ready = !full[wr_sel];
  assign rd_avail = full[rd_sel];
  assign wr_take  = wr_en && wr_ready;
  assign wr_hand  = wr_done && wr_ready;
  assign rd_take  = rd_en && rd_avail;
  assign rd_rel   = rd_done && rd_avail;

  // Full flags: a handoff marks the producer's bank full, a release marks the
  // consumer's bank empty; when both happen they hit different banks.
  always_comb begin
    full_next = full;
    if (wr_hand) full_next[wr_sel] = 1'b1;
    if (rd_rel)  full_next[rd_sel] = 1'b0;
  end

  // Ownership registers and full flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full   <= 2'b00;
    end else begin
      full <= full_next;
      if (wr_hand) wr_sel <= !wr_sel;
      if (rd_rel)  rd_sel <= !rd_sel;
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_take) begin
      if (wr_sel) bank1[wr_addr] <= wr_data;
      else        bank0[wr_addr] <= wr_data;
    end
  end

  // Synchronous memory read, kept free of reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (rd_take) raw_word <= rd_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

  // Valid bit tracking the first read stage; reset drops in-flight reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) s1_valid <= 1'b0;
    else          s1_valid <= rd_take;
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      logic seen;

      // Remembers whether raw_word has been loaded since reset, so the
      // output reads zero until the first real read lands.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) seen <= 1'b0;
        else if (rd_take) seen <= 1'b1;
      end

      assign rd_valid = s1_valid;
      assign rd_data  = seen ? raw_word : '0;
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic             v2;
      logic [WIDTH-1:0] d2;

      // Output register stage; holds the last delivered word.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= s1_valid;
          if (s1_valid) d2 <= raw_word;
        end
      end

      assign rd_valid = v2;
      assign rd_data  = d2;
    end else begin : g_bad_latency
      $error("pingpong_bram: READ_LATENCY must be 1 or 2, got %0d", READ_LATENCY);
      assign rd_valid = 1'b0;
      assign rd_data  = '0;
    end
  endgenerate

`ifdef PINGPONG_SWAP_CNT_EN
  // Counts accepted handoffs, wrapping naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     swap_count <= 16'd0;
    else if (wr_hand) swap_count <= swap_count + 16'd1;
  end
`endif

endmodule
